mem_burst: RTL

Multi-byte transfer engine between the CHIP-8 core's instruction sequencer and the 4 KiB `mem` block. It performs bursts of 1–16 consecutive bytes, handling the sprite fetch for DXYN, FX55/FX65 register save/restore and BCD stores. Reads drive `mem`'s read/ack port and present bytes on a valid/ready output stream. Writes accept bytes on a valid/ready input stream and drive `mem`'s write port.

---
 rtl/mem_burst.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_burst.sv
// mem_burst: 1..MAX_LEN-byte read/write burst engine between the CHIP-8 sequencer and mem (MEM_BURST_PIPE_EN overlaps reads).
// Latency: read 3 cycles/byte (2 with MEM_BURST_PIPE_EN), write 1 byte/cycle; done pulses one cycle after the last byte.
// Backpressure: out_ready low holds RD_OUT with out_byte frozen; in_valid low in WR stalls with no write.
module mem_burst #(
    parameter int MAX_LEN = 16,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          dir,
    input  logic [11:0]   base,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_read,
    output logic [11:0]   mem_read_idx,
    input  logic [7:0]    mem_read_byte,
    input  logic          mem_read_ack,
    output logic          mem_write,
    output logic [11:0]   mem_write_idx,
    output logic [7:0]    mem_write_byte,
    output logic          out_valid,
    output logic [7:0]    out_byte,
    input  logic          out_ready,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_OUT  = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]    state;
    logic [11:0]   addr;
    logic [LW-1:0] remain;
    logic          rd_hs;
    logic          rd_more;

    assign rd_hs = (state == RD_OUT) && out_ready;
`ifdef MEM_BURST_PIPE_EN
    // Issue the next read in the same cycle the current byte is accepted.
    assign rd_more = rd_hs && (remain != '0);
`else
    assign rd_more = 1'b0;
`endif

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign mem_read       = (state == RD_REQ) || rd_more;
    assign mem_read_idx   = mem_read ? addr : 12'h000;
    assign in_ready       = (state == WR);
    assign mem_write      = in_ready && in_valid;
    assign mem_write_idx  = in_ready ? addr : 12'h000;
    assign mem_write_byte = in_ready ? in_byte : 8'h00;
    assign out_valid      = (state == RD_OUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr     <= 12'h000;
            remain   <= '0;
            out_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr   <= base;
                        remain <= len;
                        if (len == '0)
                            state <= DONE;
                        else if (dir)
                            state <= WR;
                        else
                            state <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_read_ack) begin
                        out_byte <= mem_read_byte;
                        addr     <= addr + 12'd1;
                        remain   <= remain - LW'(1);
                        state    <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (rd_hs) begin
                        if (remain == '0)
                            state <= DONE;
                        else if (rd_more)
                            state <= RD_WAIT;
                        else
                            state <= RD_REQ;
                    end
                end
                WR: begin
                    if (in_valid) begin
                        addr   <= addr + 12'd1;
                        remain <= remain - LW'(1);
                        if (remain == LW'(1))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
